aes_cipher_iter: RTL
====================

# aes_cipher_iter

Iterative AES forward cipher that consumes the round-key schedule produced by the key-expansion stage. It performs one cipher round per clock. It accepts one 128-bit plaintext block per transaction over a valid/ready handshake and returns the ciphertext over a second valid/ready handshake. It fetches round key `r` by driving a round index to the key-expansion output and reading the selected 128-bit round key back combinationally.

## Interface
- `Nr`, 14, number of rounds. The legal values are 10, 12 and 14, selecting AES-128, AES-192 and AES-256.
- `Nb`, 4, columns per state. This value is fixed at 4 and no other value is supported.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `SBox`  in  8 x [0:255]  forward S-box table, as supplied by the const package.
- `in_valid`  in  1  a plaintext block is presented.
- `in_ready`  out  1  the block can accept a plaintext.
- `in_data`  in  128  plaintext. Byte 0 is bits [127:120]. Column-major per FIPS-197: byte 4c+r is state s[r][c].
- `rk_index`  out  4  round-key number requested (0..Nr).
- `rk_data`  in  128  round key `rk_index`, made of words w[4i]..w[4i+3]. Word w[4i+c] is bits [127-32c -: 32]. This input is combinational from `rk_index`.
- `out_valid`  out  1  ciphertext is available.
- `out_ready`  in  1  the consumer takes the ciphertext.
- `out_data`  out  128  ciphertext, using the same byte order as `in_data`.

## Operation
- **States.**
  - IDLE: `in_ready`=1 and `rk_index`=0.
  - ROUND: round counter `rnd` runs 1..Nr and `rk_index`=`rnd`.
  - DONE: `out_valid`=1 and `rk_index`=0.
- **IDLE.** When `in_valid`&`in_ready` on an edge:
  - `st` <= `in_data` ^ `rk_data` (initial AddRoundKey with round key 0).
  - `rnd` <= 1, and the state moves to ROUND.
- **ROUND.** Each edge:
  - `st` <= AddRoundKey(MixColumns(ShiftRows(SubBytes(`st`))), `rk_data`).
  - MixColumns is bypassed when `rnd`==Nr.
  - If `rnd`==Nr, go to DONE. Otherwise `rnd` <= `rnd`+1.
- **DONE.**
  - `out_data`=`st`.
  - On `out_valid`&`out_ready`, go to IDLE.
  - Otherwise hold; `out_data` stays stable.
- **Datapath arithmetic.**
  - SubBytes indexes `SBox` per byte.
  - ShiftRows rotates row r left by r columns.
  - MixColumns uses xtime in GF(2^8) mod 0x11B: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - All datapath is 8-bit XOR only; there is no carry arithmetic.
- **Handshake isolation.**
  - `in_valid` and `in_data` are ignored outside IDLE; the block latches the plaintext at acceptance only.
  - `out_ready` is ignored outside DONE.
  - `in_ready` and `out_valid` are never both 1.
- **Key requirements.**
  - `rk_data` must be valid combinationally for the driven `rk_index` in the same cycle.
  - The key must not change between acceptance and completion. If it does, the result is undefined, though the protocol still completes.

## Timing
- **Reset** (`reset`=0 at an edge):
  - State returns to IDLE, `rnd`=0 and `st`=0.
  - While `reset` is low: `in_ready`=0, `out_valid`=0, `out_data`=0, `rk_index`=0.
  - `in_ready`=1 from the first cycle after `reset` is sampled high.
- **Reset mid-operation** (in ROUND or DONE): the in-flight block is discarded and no `out_valid` pulse is produced.
- **Latency.** With acceptance at edge 0, rounds occur at edges 1..Nr and `out_valid` is high from the cycle after edge Nr. That is 15 cycles for AES-256, counting the acceptance cycle.
- **Throughput.**
  - At best, one block per Nr+2 cycles: the acceptance cycle, then Nr ROUND cycles, then one DONE cycle with `out_ready`=1.
  - `in_ready` returns high the cycle after the output handshake. There is no overlap of consecutive blocks.
- **Back-pressure.** With `out_ready`=0, DONE holds indefinitely. `out_data` and `out_valid` stay constant.
- **`rk_index` sequence** per block: 0 (IDLE), 1, 2, …, Nr (ROUND), 0 (DONE).

## Test plan
- **AES-256, Nr=14.** Key 000102…1f, plaintext 00112233445566778899aabbccddeeff. Response: `out_data`=8ea2b7ca516745bfeafc49904b496089, with `out_valid` rising exactly 14 edges after acceptance and `rk_index` stepping 0,1..14,0.
- **AES-128, Nr=10.** Key 000102…0f, same plaintext. Response: `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a after 10 round edges.
- **Back-pressure.** Hold `out_ready`=0 for 20 cycles in DONE. Required: `out_data` stable and `in_ready`=0 throughout. Asserting `in_valid` with new data during this period must not alter the result.
- **Back-to-back.** Keep `in_valid`=1 and `out_ready`=1 for two vectors. Required: the second acceptance occurs exactly 1 cycle after the first output handshake, and both ciphertexts are correct.
- **Reset mid-round.** Pull `reset` low at `rnd`=7 for 1 cycle. Required: no `out_valid`, `in_ready`=1 in the cycle after release, and the next vector yields the correct ciphertext.
- **Reset values.** While `reset` is low, check `in_ready`=0, `out_valid`=0, `out_data`=0 and `rk_index`=0.

Source files
------------

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES forward cipher, one round per clock.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-low reset
//   SBox             forward S-box table (256 x 8)
//   in_valid/ready   plaintext handshake, in_data 128-bit block
//   rk_index/data    round-key request; rk_data is combinational from it
//   out_valid/ready  ciphertext handshake, out_data 128-bit block
// Byte k of any 128-bit block sits at bits [127-8k -: 8]; byte 4c+r is s[r][c].
module aes_cipher_iter #(
    parameter int Nr = 14,
    parameter int Nb = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   SBox [0:255],
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_index,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int NBYTES = 4 * Nb;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    state_t                  state;
    logic [3:0]              rnd;
    logic [127:0]            st;
    logic [127:0]            nxt;
    logic                    last;
    logic [NBYTES-1:0][7:0]  sb;
    logic [NBYTES-1:0][7:0]  sr;
    logic [NBYTES-1:0][7:0]  mc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    assign last = (rnd == 4'(Nr));

    // rnd is 0 outside ROUND, so it doubles as the round-key index.
    assign rk_index = rnd;

    always_comb begin
        sb  = '0;
        sr  = '0;
        mc  = '0;
        nxt = '0;
        for (int k = 0; k < NBYTES; k++) begin
            sb[k] = SBox[st[127-8*k -: 8]];
        end
        // Row r of column c takes the byte from column c+r.
        for (int c = 0; c < Nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%Nb)+r];
            end
        end
        for (int c = 0; c < Nb; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                      ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1]
                      ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        // The final round skips MixColumns.
        for (int k = 0; k < NBYTES; k++) begin
            nxt[127-8*k -: 8] = (last ? sr[k] : mc[k]) ^ rk_data[127-8*k -: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            rnd       <= '0;
            st        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        st       <= in_data ^ rk_data;
                        rnd      <= 4'd1;
                        in_ready <= 1'b0;
                        state    <= ROUND;
                    end
                end
                ROUND: begin
                    st <= nxt;
                    if (last) begin
                        rnd       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= nxt;
                        state     <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
